lcd_byte_writer: RTL and testbench
==================================

Name: lcd_byte_writer

Overview:
- Responder end of the CPU-to-LCD byte handshake. The MiniAlu core raises a one-cycle data-ready strobe with an 8-bit value; this block accepts the byte and drives the Spartan-3E character LCD.
- The LCD is driven over its 4-bit, write-only bus: power-on init, high/low nibble split, E-pulse timing and post-byte wait.
- Sits between the CPU's LCD instruction path and the board pins.

Parameters:
- POWERON_WAIT, 750000, cycles idle after reset before first init nibble (15 ms @50 MHz)
- INIT_WAIT1, 205000, cycles after first 0x3 init nibble (4.1 ms)
- INIT_WAIT2, 5000, cycles after second 0x3 init nibble (100 us)
- INIT_WAIT3, 2000, cycles after third 0x3 and after 0x2 init nibbles (40 us)
- NIB_SETUP, 2, cycles data/RS stable before E rises
- NIB_EN, 12, cycles E held high
- NIB_HOLD, 1, cycles data held after E falls
- NIB_GAP, 50, cycles between high and low nibble of one byte (1 us)
- BYTE_WAIT, 2000, cycles after each byte before next accept (40 us)
- CLEAR_WAIT, 82000, post-byte wait for command bytes 0x01/0x02 (1.64 ms)

Ports:
- Clock  input  1  system clock, 50 MHz
- Reset  input  1  asynchronous, active-low reset
- iData  input  8  byte to write
- iIsCommand  input  1  1 = instruction register (RS=0), 0 = character data (RS=1)
- iData_Ready  input  1  request strobe from CPU
- oReadyForData  output  1  high only when idle and able to accept a byte
- oLCD_Enabled  output  1  LCD E pulse
- oLCD_RegisterSelect  output  1  LCD RS
- oLCD_ReadWrite  output  1  constant 0 (write only)
- oLCD_StrataFlashControl  output  1  constant 1 (StrataFlash disabled, LCD owns shared bus)
- oLCD_Data  output  4  LCD DB[7:4]

Behaviour:
- Reset (asynchronous, Reset=0) outputs: oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oReadyForData=0.
- Reset handling: the state machine goes to PWR_WAIT and the wait counter (20 bit) clears. Reset mid-transfer aborts immediately; the full init sequence reruns after release.
- States: PWR_WAIT -> INIT_NIB -> CFG -> IDLE -> SEND_HI -> GAP -> SEND_LO -> POST_WAIT -> IDLE.
- PWR_WAIT: count POWERON_WAIT cycles.
- INIT_NIB: send nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. After each, wait INIT_WAIT1, INIT_WAIT2, INIT_WAIT3, INIT_WAIT3 respectively.
- CFG: send command bytes 0x28, 0x06, 0x0C, 0x01, each as a full byte transfer.
  - Post-waits are BYTE_WAIT, except 0x01, which uses CLEAR_WAIT.
  - Then enter IDLE.
- Nibble transfer, cycle 0 = first cycle in state:
  - Data/RS are driven from cycle 0.
  - E is high for cycles NIB_SETUP .. NIB_SETUP+NIB_EN-1.
  - Data is held NIB_HOLD further cycles.
  - Total nibble length is NIB_SETUP+NIB_EN+NIB_HOLD.
- oReadyForData is registered and equals (state==IDLE).
- Accept occurs at a rising edge with iData_Ready=1 and oReadyForData=1.
  - iData and iIsCommand are latched; oReadyForData=0 from the next cycle.
  - SEND_HI starts that cycle, driving iData[7:4].
  - iData_Ready while not ready is ignored (not queued).
- GAP lasts NIB_GAP cycles with E=0; SEND_LO then drives iData[3:0].
- POST_WAIT lasts BYTE_WAIT cycles. If the latched command is 0x01 or 0x02 with iIsCommand=1, it lasts CLEAR_WAIT instead.
- Accept-to-ready latency = 2*(NIB_SETUP+NIB_EN+NIB_HOLD)+NIB_GAP+post-wait+1. Defaults: 2081 cycles for data, 82081 for clear.
- RS equals ~iIsCommand (latched) for the whole byte, and holds its value between transfers.
- Wait-counter compares are exact (terminal count = param-1). A parameter of 0 is illegal.

Optional Feature:
LCD_AUTO_WRAP_EN
- Defined: a 5-bit column counter increments on each data byte (iIsCommand=0).
- After the 16th character on line 1, the block inserts command 0xC0 (BYTE_WAIT post-wait) before returning to IDLE. After the 16th on line 2, it inserts 0x80. The line flag toggles each wrap.
- Commands 0x01/0x02 and the init 0x01 clear column and line.
- oReadyForData stays low until the inserted command completes.
- Undefined: no counter, no inserted commands; the LCD's native addressing applies.

Test Plan:
- Bench parameters for all scenarios: POWERON_WAIT=20, INIT_WAIT1=10, INIT_WAIT2=8, INIT_WAIT3=6, BYTE_WAIT=30, CLEAR_WAIT=60, timing defaults otherwise.
- Release Reset -> oReadyForData=0; E pulses 4x with oLCD_Data 3,3,3,2, RS=0. Then bytes 28,06,0C,01 appear as nibble pairs; oReadyForData=1 after the clear's 60-cycle wait.
- Idle, iData=8'h41, iIsCommand=0, one-cycle iData_Ready -> RS=1; nibble 4 then 1, each with E high 12 cycles, 50-cycle gap. oReadyForData returns high exactly 2*15+50+30+1=111 cycles after accept.
- iIsCommand=1, iData=8'h01 -> RS=0, nibbles 0 then 1; ready after 2*15+50+60+1=141 cycles.
- iData_Ready pulsed 5 cycles after accept with iData=8'h42 -> ignored; only 0x41 nibbles observed.
- Reset asserted during E-high of low nibble -> E=0, oLCD_Data=0, oReadyForData=0 immediately; full init sequence repeats after release.
- With LCD_AUTO_WRAP_EN: 17 data bytes -> after the 16th, command nibbles C,0 with RS=0 precede ready; the 17th is written normally.

Source files
------------

// File: rtl/lcd_byte_writer.sv
// Accepts a byte from the CPU handshake and writes it to the Spartan-3E character LCD over the 4-bit bus.
// Define LCD_AUTO_WRAP_EN to insert line-change commands after 16 characters per line.
module lcd_byte_writer #(
  parameter int POWERON_WAIT = 750000,
  parameter int INIT_WAIT1   = 205000,
  parameter int INIT_WAIT2   = 5000,
  parameter int INIT_WAIT3   = 2000,
  parameter int NIB_SETUP    = 2,
  parameter int NIB_EN       = 12,
  parameter int NIB_HOLD     = 1,
  parameter int NIB_GAP      = 50,
  parameter int BYTE_WAIT    = 2000,
  parameter int CLEAR_WAIT   = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iIsCommand,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);
  localparam int CW = 20;
  localparam logic [CW-1:0] NIB_LAST = CW'(NIB_SETUP + NIB_EN + NIB_HOLD - 1);
  localparam logic [CW-1:0] E_ON     = CW'(NIB_SETUP);
  localparam logic [CW-1:0] E_OFF    = CW'(NIB_SETUP + NIB_EN);
  localparam logic [CW-1:0] NIB_LEN  = CW'(NIB_SETUP + NIB_EN + NIB_HOLD);

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, CFG, IDLE, SEND_HI, GAP, SEND_LO, POST_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            cfg_q, cfg_d;
  logic [7:0]      data_q, data_d;
  logic            cmd_q, cmd_d;
  logic            rs_q, rs_d;
  logic            rdy_q, rdy_d;
`ifdef LCD_AUTO_WRAP_EN
  logic [4:0]      col_q, col_d;
  logic            line_q, line_d;
  logic            wrap_q, wrap_d;
`endif

  logic            accept, is_clear, e_win, lcd_e;
  logic [3:0]      lcd_d;
  logic [CW-1:0]   init_term, post_term;
  logic [7:0]      cfg_byte;

  assign accept    = iData_Ready && rdy_q;
  assign is_clear  = cmd_q && (data_q == 8'h01 || data_q == 8'h02);
  assign post_term = is_clear ? CW'(CLEAR_WAIT - 1) : CW'(BYTE_WAIT - 1);
  assign e_win     = (cnt_q >= E_ON) && (cnt_q < E_OFF);

  // Init step covers the nibble itself plus its settling wait in one count.
  always_comb begin
    case (idx_q)
      2'd0:    init_term = CW'(NIB_SETUP + NIB_EN + NIB_HOLD + INIT_WAIT1 - 1);
      2'd1:    init_term = CW'(NIB_SETUP + NIB_EN + NIB_HOLD + INIT_WAIT2 - 1);
      default: init_term = CW'(NIB_SETUP + NIB_EN + NIB_HOLD + INIT_WAIT3 - 1);
    endcase
    case (idx_q)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    rs_d    = rs_q;
    lcd_e   = 1'b0;
    lcd_d   = 4'h0;
`ifdef LCD_AUTO_WRAP_EN
    col_d   = col_q;
    line_d  = line_q;
    wrap_d  = wrap_q;
`endif
    case (state_q)
      PWR_WAIT: if (cnt_q == CW'(POWERON_WAIT - 1)) begin
        state_d = INIT_NIB;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
      INIT_NIB: begin
        if (cnt_q < NIB_LEN) begin
          lcd_d = (idx_q == 2'd3) ? 4'h2 : 4'h3;
          lcd_e = e_win;
        end
        if (cnt_q == init_term) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = CFG;
            cfg_d   = 1'b1;
          end
        end
      end
      CFG: begin
        data_d  = cfg_byte;
        cmd_d   = 1'b1;
        rs_d    = 1'b0;
        cnt_d   = '0;
        state_d = SEND_HI;
      end
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          data_d  = iData;
          cmd_d   = iIsCommand;
          rs_d    = ~iIsCommand;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        lcd_d = data_q[7:4];
        lcd_e = e_win;
        if (cnt_q == NIB_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: if (cnt_q == CW'(NIB_GAP - 1)) begin
        state_d = SEND_LO;
        cnt_d   = '0;
      end
      SEND_LO: begin
        lcd_d = data_q[3:0];
        lcd_e = e_win;
        if (cnt_q == NIB_LAST) begin
          state_d = POST_WAIT;
          cnt_d   = '0;
        end
      end
      POST_WAIT: if (cnt_q == post_term) begin
        cnt_d   = '0;
        state_d = IDLE;
`ifdef LCD_AUTO_WRAP_EN
        if (is_clear) begin
          col_d  = '0;
          line_d = 1'b0;
        end
`endif
        if (cfg_q) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) cfg_d = 1'b0;
          else               state_d = CFG;
        end
`ifdef LCD_AUTO_WRAP_EN
        else if (wrap_q) begin
          wrap_d = 1'b0;
        end else if (!cmd_q) begin
          // 16th character on this line: move the cursor to the other line.
          if (col_q == 5'd15) begin
            col_d   = '0;
            line_d  = ~line_q;
            data_d  = line_q ? 8'h80 : 8'hC0;
            cmd_d   = 1'b1;
            rs_d    = 1'b0;
            wrap_d  = 1'b1;
            state_d = SEND_HI;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
`endif
      end
      default: state_d = PWR_WAIT;
    endcase
    rdy_d = (state_q == IDLE) && !accept;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      cfg_q   <= 1'b0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      rs_q    <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
      col_q   <= '0;
      line_q  <= 1'b0;
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      rs_q    <= rs_d;
      rdy_q   <= rdy_d;
`ifdef LCD_AUTO_WRAP_EN
      col_q   <= col_d;
      line_q  <= line_d;
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign oReadyForData           = rdy_q;
  assign oLCD_Enabled            = lcd_e;
  assign oLCD_Data               = lcd_d;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;
endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: per-cycle byte-transfer model, E-pulse capture, init and reset scenarios.
module tb_lcd_byte_writer;
  localparam int PW = 20, IW1 = 10, IW2 = 8, IW3 = 6, BW = 30, CWT = 60;
  localparam int NS = 2, NE = 12, NH = 1, NG = 50, NL = NS + NE + NH;
  localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                            4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  logic       Clock = 1'b0, Reset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iIsCommand = 1'b0, iData_Ready = 1'b0;
  logic       oReadyForData, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_byte_writer #(
    .POWERON_WAIT(PW), .INIT_WAIT1(IW1), .INIT_WAIT2(IW2), .INIT_WAIT3(IW3),
    .BYTE_WAIT(BW), .CLEAR_WAIT(CWT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iIsCommand(iIsCommand),
    .iData_Ready(iData_Ready), .oReadyForData(oReadyForData), .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pw(input logic [7:0] b, input bit c);
    return (c && (b == 8'h01 || b == 8'h02)) ? CWT : BW;
  endfunction
  function automatic int seg_len(input logic [7:0] b, input bit c);
    return 2 * NL + NG + pw(b, c);
  endfunction

  // Model: one accepted byte (plus an optional inserted wrap command) as timed segments.
  int         cyc = 0, t0 = 0, nseg = 1, m_col = 0, tacc = 0;
  bit         armed = 0, busy = 0, m_rs = 0, m_line = 0;
  logic [7:0] sb [2];
  bit         scmd [2];

  always @(posedge Clock) begin
    cyc++;
    if (armed && !busy && iData_Ready) begin
      busy = 1; t0 = cyc; nseg = 1; sb[0] = iData; scmd[0] = iIsCommand;
      if (iIsCommand && (iData == 8'h01 || iData == 8'h02)) begin m_col = 0; m_line = 0; end
`ifdef LCD_AUTO_WRAP_EN
      if (!iIsCommand) begin
        m_col++;
        if (m_col == 16) begin
          m_col = 0; nseg = 2; scmd[1] = 1; sb[1] = m_line ? 8'h80 : 8'hC0; m_line = ~m_line;
        end
      end
`endif
    end
  end

  always @(negedge Clock) begin
    int c, o, s, w0, tot;
    bit e, dv, rdy;
    logic [3:0] d;
    if (armed && Reset) begin
      e = 0; dv = 0; d = 4'h0; rdy = 1;
      if (busy) begin
        c = cyc - t0;
        w0 = seg_len(sb[0], scmd[0]);
        tot = (nseg == 2) ? w0 + seg_len(sb[1], scmd[1]) : w0;
        s = (nseg == 2 && c >= w0) ? 1 : 0;
        o = (s == 1) ? c - w0 : c;
        if (c > tot) busy = 0;
        else begin
          rdy = 0; m_rs = ~scmd[s];
          if (o < NL) begin
            dv = 1; d = sb[s][7:4]; e = (o >= NS && o < NS + NE);
          end else if (o >= NL + NG && o < 2 * NL + NG) begin
            dv = 1; d = sb[s][3:0]; e = (o - NL - NG >= NS && o - NL - NG < NS + NE);
          end
        end
      end
      chk("E", oLCD_Enabled, e);
      chk("ready", oReadyForData, rdy);
      chk("RS", oLCD_RegisterSelect, m_rs);
      chk("rw_const", oLCD_ReadWrite, 0);
      if (dv) chk("data", oLCD_Data, d);
    end
  end

  // E-pulse monitor: captures {RS,data} on each rising E, checks pulse width and data stability.
  bit         pe = 0;
  int         ew = 0, last_e_cyc = 0;
  logic [3:0] ed;
  logic [4:0] q [$];
  always @(negedge Clock) begin
    if (!Reset) pe = 0;
    else begin
      if (oLCD_Enabled && !pe) begin
        q.push_back({oLCD_RegisterSelect, oLCD_Data}); ew = 1; ed = oLCD_Data;
      end else if (oLCD_Enabled) begin
        ew++; chk("e_data_stable", oLCD_Data, ed);
      end else if (pe) chk("e_width", ew, NE);
      if (oLCD_Enabled) last_e_cyc = cyc;
      pe = oLCD_Enabled;
    end
  end

  task automatic do_init();
    int n;
    q.delete(); armed = 0; busy = 0; m_rs = 0; m_col = 0; m_line = 0;
    @(negedge Clock); Reset = 1;
    n = 0;
    while (!oReadyForData && n < 5000) begin @(negedge Clock); n++; end
    chk("init_timeout", int'(n < 5000), 1);
    chk("init_count", q.size(), 12);
    for (int i = 0; i < 12 && i < q.size(); i++) chk("init_nib", q[i], {1'b0, INIT_NIBS[i]});
    chk("init_clear_wait", cyc - last_e_cyc, NH + CWT + 2);
    armed = 1;
  endtask

  task automatic send(input logic [7:0] b, input bit c);
    int n = 0;
    while (!oReadyForData && n < 1000) begin @(negedge Clock); n++; end
    chk("send_timeout", int'(n < 1000), 1);
    iData = b; iIsCommand = c; iData_Ready = 1;
    @(negedge Clock); iData_Ready = 0; tacc = cyc;
  endtask

  task automatic wait_rdy(output int lat);
    int n = 0;
    while (!oReadyForData && n < 1000) begin @(negedge Clock); n++; end
    chk("ready_timeout", int'(n < 1000), 1);
    lat = cyc - tacc;
  endtask

  initial begin
    int lat, exp_lat;
    logic [7:0] b;
    bit c;
    #1 Reset = 0;
    repeat (3) @(negedge Clock);
    chk("rst_E", oLCD_Enabled, 0);
    chk("rst_RS", oLCD_RegisterSelect, 0);
    chk("rst_data", oLCD_Data, 0);
    chk("rst_ready", oReadyForData, 0);
    chk("rst_rw", oLCD_ReadWrite, 0);
    chk("rst_sf", oLCD_StrataFlashControl, 1);
    do_init();

    q.delete(); send(8'h41, 0); wait_rdy(lat);
    chk("lat_41", lat, 111);
    chk("n_41", q.size(), 2);
    if (q.size() == 2) begin chk("nib_41_hi", q[0], 5'h14); chk("nib_41_lo", q[1], 5'h11); end

    q.delete(); send(8'h01, 1); wait_rdy(lat);
    chk("lat_clr", lat, 141);
    chk("n_clr", q.size(), 2);
    if (q.size() == 2) begin chk("nib_clr_hi", q[0], 5'h00); chk("nib_clr_lo", q[1], 5'h01); end

    q.delete(); send(8'h41, 0);
    repeat (4) @(negedge Clock);
    iData = 8'h42; iData_Ready = 1; @(negedge Clock); iData_Ready = 0;
    wait_rdy(lat);
    chk("lat_ign", lat, 111);
    repeat (5) @(negedge Clock);
    chk("n_ign", q.size(), 2);
    if (q.size() == 2) begin chk("nib_ign_hi", q[0], 5'h14); chk("nib_ign_lo", q[1], 5'h11); end

`ifdef LCD_AUTO_WRAP_EN
    send(8'h01, 1); wait_rdy(lat);
    for (int i = 0; i < 17; i++) begin
      q.delete(); send(8'h30 + 8'(i), 0); wait_rdy(lat);
      if (i == 15) begin
        chk("wrap_lat", lat, 221);
        chk("wrap_n", q.size(), 4);
        if (q.size() == 4) begin chk("wrap_c", q[2], 5'h0C); chk("wrap_0", q[3], 5'h00); end
      end else chk("nowrap_lat", lat, 111);
    end
`endif

    repeat (20) begin
      b = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin b = 8'($urandom_range(1, 2)); c = 1; end
      q.delete(); send(b, c);
      exp_lat = seg_len(b, c) + 1 + ((nseg == 2) ? seg_len(sb[1], scmd[1]) : 0);
      wait_rdy(lat);
      chk("rand_lat", lat, exp_lat);
      chk("rand_first_nib", (q.size() > 0) ? int'(q[0]) : -1, {~c, b[7:4]});
      repeat ($urandom_range(0, 3)) @(negedge Clock);
    end

    // Reset during E-high of the low nibble.
    send(8'h41, 0);
    repeat (70) @(negedge Clock);
    chk("mid_E_before", oLCD_Enabled, 1);
    #1 armed = 0; Reset = 0;
    #1;
    chk("mid_rst_E", oLCD_Enabled, 0);
    chk("mid_rst_data", oLCD_Data, 0);
    chk("mid_rst_ready", oReadyForData, 0);
    repeat (3) @(negedge Clock);
    do_init();
    q.delete(); send(8'h41, 0); wait_rdy(lat);
    chk("post_rst_lat", lat, 111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
